fb_mem_arbiter: RTL and testbench

- Shares one single-port frame-buffer memory between two requesters: the display line prefetch and a CPU/pixel-writer port.
- On each line_req it fetches one full scanline (H_PIXELS words) into the display line buffer. The line buffer is then drained by the VGA pixel path.
- Display fetch has priority. A burst limit guarantees CPU forward progress.
- Sits between the frame buffer memory controller and the display pixel generator.

---
 rtl/fb_mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_fb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_mem_arbiter.sv
// Frame-buffer memory arbiter: display scanline prefetch (priority, burst-limited) vs CPU port.
// Optional FB_UNDERRUN_CNT_EN adds a saturating underrun counter with synchronous clear.
//
// state | meaning
// IDLE  | no transaction; pending line -> DISP, else CPU request -> CPU
// DISP  | issuing display reads base+n into the line buffer
// CPU   | one CPU read/write in flight, then back to DISP or IDLE
module fb_mem_arbiter #(
  parameter int H_PIXELS  = 640,
  parameter int V_LINES   = 480,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 16,
  parameter int BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_req,
  input  logic [9:0]        line_idx,
  output logic              fetch_busy,
  output logic              line_done,
  output logic              underrun,
  output logic              lb_we,
  output logic [9:0]        lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef FB_UNDERRUN_CNT_EN
  output logic [15:0]       underrun_cnt,
  input  logic              underrun_clr,
`endif
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [9:0] LAST = 10'(H_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, DISP, CPU} state_t;

  state_t            state, state_nxt;
  logic [9:0]        n;
  logic [BW-1:0]     burst_left;
  logic              line_pending, discard, done_pend;
  logic [ADDR_W-1:0] base, base_new, disp_addr;
  logic              acc, restart, ack, cpu_free, burst_hit;
  logic              issue_disp, issue_cpu, drop_req, disp_word, last_word, cpu_done, burst_load;

  assign acc       = line_req && ({22'd0, line_idx} < 32'(V_LINES));
  assign restart   = acc && fetch_busy;
  assign ack       = mem_req && mem_ack;
  // cpu_req is still high in the cpu_ack cycle; do not serve that request twice
  assign cpu_free  = cpu_req && !cpu_ack;
  assign burst_hit = burst_left <= BW'(1);
  assign base_new  = ADDR_W'(line_idx) * ADDR_W'(H_PIXELS);

  always_comb begin
    state_nxt  = state;
    issue_disp = 1'b0;
    issue_cpu  = 1'b0;
    drop_req   = 1'b0;
    disp_word  = 1'b0;
    last_word  = 1'b0;
    cpu_done   = 1'b0;
    burst_load = 1'b0;
    disp_addr  = base + ADDR_W'(n);
    unique case (state)
      IDLE: begin
        if (line_pending || acc) begin
          state_nxt  = DISP;
          burst_load = 1'b1;
        end else if (cpu_free) begin
          state_nxt = CPU;
          issue_cpu = 1'b1;
        end
      end
      DISP: begin
        if (ack) begin
          drop_req = 1'b1;
          // a restarted line drops the completing read; reissue from the new base next cycle
          if (!(discard || restart)) begin
            disp_word = 1'b1;
            if (n == LAST) begin
              last_word = 1'b1;
              state_nxt = IDLE;
            end else if (burst_hit && cpu_free) begin
              state_nxt  = CPU;
              issue_cpu  = 1'b1;
              burst_load = 1'b1;
            end else begin
              issue_disp = 1'b1;
              disp_addr  = base + ADDR_W'(n) + ADDR_W'(1);
            end
          end
        end else if (!mem_req && !restart) begin
          issue_disp = 1'b1;
        end
      end
      CPU: begin
        if (ack) begin
          drop_req  = 1'b1;
          cpu_done  = 1'b1;
          state_nxt = (line_pending || acc) ? DISP : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      n            <= '0;
      burst_left   <= '0;
      line_pending <= 1'b0;
      discard      <= 1'b0;
      done_pend    <= 1'b0;
      base         <= '0;
      fetch_busy   <= 1'b0;
      line_done    <= 1'b0;
      underrun     <= 1'b0;
      lb_we        <= 1'b0;
      lb_waddr     <= '0;
      lb_wdata     <= '0;
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      state     <= state_nxt;
      underrun  <= restart;
      done_pend <= last_word;
      line_done <= done_pend && !restart;
      lb_we     <= disp_word;
      if (disp_word) begin
        lb_waddr <= n;
        lb_wdata <= mem_rdata;
      end
      cpu_ack <= cpu_done;
      if (cpu_done && !mem_we) cpu_rdata <= mem_rdata;

      if (issue_disp) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= disp_addr;
        mem_wdata <= '0;
      end else if (issue_cpu) begin
        mem_req   <= 1'b1;
        mem_we    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (drop_req) begin
        mem_req <= 1'b0;
      end

      if (acc) begin
        base         <= base_new;
        n            <= '0;
        line_pending <= 1'b1;
      end else begin
        if (disp_word) n <= n + 10'd1;
        if (last_word) line_pending <= 1'b0;
      end

      if (restart && state == DISP && mem_req && !mem_ack) discard <= 1'b1;
      else if (ack) discard <= 1'b0;

      if (acc) fetch_busy <= 1'b1;
      else if (done_pend) fetch_busy <= 1'b0;

      if (burst_load) burst_left <= BW'(BURST_MAX);
      else if (disp_word && burst_left != '0) burst_left <= burst_left - BW'(1);
    end
  end

`ifdef FB_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) underrun_cnt <= '0;
    else if (underrun_clr) underrun_cnt <= '0;
    else if (underrun && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter with a behavioural memory (data = function of address).
// Underrun-counter checks are compiled in when FB_UNDERRUN_CNT_EN is defined.
module tb_fb_mem_arbiter;
  localparam logic [18:0] CPU_BASE = 19'h70000;
  localparam logic [9:0]  LAST     = 10'd639;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        line_req = 1'b0;
  logic [9:0]  line_idx = '0;
  logic        fetch_busy, line_done, underrun, lb_we;
  logic [9:0]  lb_waddr;
  logic [15:0] lb_wdata;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [18:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
`ifdef FB_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
  logic        underrun_clr = 1'b0;
`endif

  always #5 clk = ~clk;

  fb_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .line_req(line_req), .line_idx(line_idx),
    .fetch_busy(fetch_busy), .line_done(line_done), .underrun(underrun),
    .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef FB_UNDERRUN_CNT_EN
    .underrun_cnt(underrun_cnt), .underrun_clr(underrun_clr),
`endif
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mdata(input logic [18:0] a);
    return a[15:0] ^ 16'h5A5A ^ {13'd0, a[18:16]};
  endfunction

  // memory: ack once mem_req has been held ack_delay cycles
  int ack_delay = 0;
  int wait_cnt = 0;
  always_comb mem_ack = mem_req && (wait_cnt >= ack_delay);
  always_comb mem_rdata = mdata(mem_addr);
  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  logic [18:0] ack_q[$];
  logic [9:0]  lbw_q[$];
  logic [15:0] lbd_q[$];
  int n_done, n_ur, busy_err, done_err, stab_err, hold, cpu_hold;
  logic [18:0] wr_addr, p_addr;
  logic [15:0] wr_data, p_wdata;
  logic prev_pend, p_we, prev_lb_we;
  logic [9:0] prev_lb_waddr;

  initial begin
    prev_pend = 1'b0; prev_lb_we = 1'b0; prev_lb_waddr = '0; hold = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_pend = 1'b0; prev_lb_we = 1'b0; hold = 0;
      end else begin
        if (prev_pend && !(mem_req && mem_addr == p_addr && mem_we == p_we && mem_wdata == p_wdata))
          stab_err++;
        prev_pend = mem_req && !mem_ack;
        p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
        if (mem_req && mem_ack) begin
          ack_q.push_back(mem_addr);
          if (mem_addr >= CPU_BASE) cpu_hold = hold;
          if (mem_we) begin wr_addr = mem_addr; wr_data = mem_wdata; end
          hold = 0;
        end else if (mem_req) hold++;
        if (lb_we) begin
          lbw_q.push_back(lb_waddr);
          lbd_q.push_back(lb_wdata);
          if (!fetch_busy) busy_err++;
        end
        if (line_done) begin
          n_done++;
          if (!prev_lb_we || prev_lb_waddr != LAST || fetch_busy) done_err++;
        end
        if (underrun) n_ur++;
        prev_lb_we = lb_we; prev_lb_waddr = lb_waddr;
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear_mon();
    ack_q.delete(); lbw_q.delete(); lbd_q.delete();
    n_done = 0; n_ur = 0; busy_err = 0; done_err = 0; stab_err = 0; cpu_hold = -1;
    wr_addr = '0; wr_data = '0;
  endtask

  task automatic start_line(input logic [9:0] idx);
    line_idx = idx; line_req = 1'b1;
    step();
    line_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int start = n_done;
    bit ok = 0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      step();
      if (n_done > start) ok = 1;
    end
    check_eq({tag, "_done_seen"}, 32'(ok), 1);
    repeat (4) step();
  endtask

  task automatic wait_lb(input int cnt);
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      step();
      if (lbw_q.size() >= cnt) ok = 1;
    end
    check_eq("lb_progress", 32'(ok), 1);
  endtask

  task automatic wait_cpu(input string tag);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      if (cpu_ack) ok = 1;
    end
    check_eq({tag, "_cpu_ack"}, 32'(ok), 1);
  endtask

  task automatic check_line(input string tag, input int start, input logic [18:0] base);
    int e = 0;
    if (lbw_q.size() < start + 640) e = 100000;
    else for (int i = 0; i < 640; i++)
      if (lbw_q[start+i] != 10'(i) || lbd_q[start+i] != mdata(base + 19'(i))) e++;
    check_eq({tag, "_lb_words"}, e, 0);
  endtask

  task automatic check_disp(input string tag, input logic [18:0] base);
    int k = 0, e = 0;
    foreach (ack_q[i])
      if (ack_q[i] < CPU_BASE) begin
        if (ack_q[i] != base + 19'(k)) e++;
        k++;
      end
    check_eq({tag, "_mem_addr"}, e, 0);
    check_eq({tag, "_disp_cnt"}, k, 640);
  endtask

  int j, e, run, ncpu, ndisp, rerr, cerr;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check_eq("rst_ctrl", {fetch_busy, line_done, underrun, lb_we, cpu_ack, mem_req, mem_we}, 0);
    check_eq("rst_addr", {lb_waddr, mem_addr}, 0);
    rst_n = 1'b1;
    step();

    // full line 2; an out-of-range request mid-fetch must be ignored
    clear_mon();
    start_line(10'd2);
    wait_lb(300);
    start_line(10'd600);
    wait_done("l2");
    check_eq("l2_lb_cnt", lbw_q.size(), 640);
    check_line("l2", 0, 19'd1280);
    check_disp("l2", 19'd1280);
    check_eq("l2_line_done_cnt", n_done, 1);
    check_eq("l2_underrun_cnt", n_ur, 0);
    check_eq("l2_busy_during", busy_err, 0);
    check_eq("l2_done_timing", done_err, 0);
    check_eq("l2_busy_after", fetch_busy, 0);

    // ignored line indices from idle
    clear_mon();
    start_line(10'd480);
    start_line(10'd1023);
    repeat (10) step();
    check_eq("ign_mem_txn", ack_q.size(), 0);
    check_eq("ign_busy", fetch_busy, 0);
    check_eq("ign_underrun", n_ur, 0);

    // CPU read from idle, granted next cycle
    clear_mon();
    cpu_we = 1'b0; cpu_addr = CPU_BASE + 19'd16; cpu_req = 1'b1;
    step();
    check_eq("cpu_grant_req", mem_req, 1);
    check_eq("cpu_grant_addr", mem_addr, CPU_BASE + 19'd16);
    wait_cpu("cpu_rd");
    cpu_req = 1'b0;
    check_eq("cpu_rd_data", cpu_rdata, mdata(CPU_BASE + 19'd16));

    // simultaneous line_req/cpu_req, then continuous CPU reads
    clear_mon();
    line_idx = 10'd5; line_req = 1'b1;
    cpu_we = 1'b0; cpu_addr = CPU_BASE; cpu_req = 1'b1;
    cerr = 0;
    fork
      begin
        step();
        line_req = 1'b0;
        wait_done("burst");
      end
      begin
        for (int k = 0; k < 40; k++) begin
          wait_cpu("burst");
          if (cpu_rdata != mdata(cpu_addr)) cerr++;
          cpu_addr = cpu_addr + 19'd1;
        end
        cpu_req = 1'b0;
      end
    join
    repeat (4) step();
    check_eq("prio_first_addr", (ack_q.size() > 0) ? ack_q[0] : 19'h7FFFF, 19'd3200);
    run = 0; ncpu = 0; ndisp = 0; rerr = 0;
    foreach (ack_q[i])
      if (ack_q[i] >= CPU_BASE) begin
        if (run != 16) rerr++;
        run = 0; ncpu++;
      end else begin
        run++; ndisp++;
      end
    check_eq("burst_run_len", rerr, 0);
    check_eq("burst_cpu_cnt", ncpu, 40);
    check_eq("burst_disp_cnt", ndisp, 640);
    check_eq("burst_cpu_rdata", cerr, 0);
    check_line("burst", 0, 19'd3200);
    check_eq("burst_line_done_cnt", n_done, 1);

    // restart at word 100 of line 2 with line 3
    clear_mon();
    start_line(10'd2);
    wait_lb(100);
    start_line(10'd3);
    wait_done("ur");
    j = -1;
    for (int i = 1; i < lbw_q.size(); i++) if (j < 0 && lbw_q[i] == 10'd0) j = i;
    check_eq("ur_restart_word", j, 100);
    if (j < 1) j = 1;
    e = 0;
    for (int i = 0; i < j; i++)
      if (lbw_q[i] != 10'(i) || lbd_q[i] != mdata(19'd1280 + 19'(i))) e++;
    check_eq("ur_old_words", e, 0);
    check_line("ur", j, 19'd1920);
    check_eq("ur_lb_cnt", lbw_q.size(), j + 640);
    check_eq("ur_ack_cnt", ack_q.size(), j + 641);
    check_eq("ur_inflight_addr", (ack_q.size() > j) ? ack_q[j] : 19'h7FFFF, 19'd1280 + 19'(j));
    check_eq("ur_new_addr", (ack_q.size() > j + 1) ? ack_q[j+1] : 19'h7FFFF, 19'd1920);
    check_eq("ur_pulses", n_ur, 1);
    check_eq("ur_line_done_cnt", n_done, 1);

    // CPU write with slow memory while line_req arrives
    clear_mon();
    ack_delay = 5;
    cpu_we = 1'b1; cpu_addr = CPU_BASE + 19'h1234; cpu_wdata = 16'hBEEF; cpu_req = 1'b1;
    step();
    start_line(10'd1);
    wait_cpu("cwr");
    cpu_req = 1'b0; cpu_we = 1'b0;
    ack_delay = 0;
    wait_done("cwr");
    check_eq("cwr_hold", cpu_hold, 5);
    check_eq("cwr_stable", stab_err, 0);
    check_eq("cwr_addr", wr_addr, CPU_BASE + 19'h1234);
    check_eq("cwr_data", wr_data, 16'hBEEF);
    check_eq("cwr_first_disp", (ack_q.size() > 1) ? ack_q[1] : 19'h7FFFF, 19'd640);
    check_eq("cwr_underrun", n_ur, 0);
    check_line("cwr", 0, 19'd640);
    check_eq("cwr_line_done_cnt", n_done, 1);

    // reset in the middle of a fetch
    clear_mon();
    start_line(10'd4);
    wait_lb(50);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_ctrl", {fetch_busy, line_done, underrun, lb_we, cpu_ack, mem_req, mem_we}, 0);
    check_eq("mrst_addr", {lb_waddr, mem_addr}, 0);
    check_eq("mrst_data", {cpu_rdata, lb_wdata}, 0);
    check_eq("mrst_wdata", mem_wdata, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
`ifdef FB_UNDERRUN_CNT_EN
    check_eq("cnt_after_reset", underrun_cnt, 0);
`endif
    clear_mon();
    start_line(10'd7);
    wait_done("post_rst");
    check_line("post_rst", 0, 19'd4480);
    check_disp("post_rst", 19'd4480);
    check_eq("post_rst_line_done_cnt", n_done, 1);

`ifdef FB_UNDERRUN_CNT_EN
    clear_mon();
    start_line(10'd0);
    wait_lb(20);
    start_line(10'd1);
    wait_lb(40);
    start_line(10'd2);
    wait_lb(60);
    start_line(10'd3);
    wait_done("cnt");
    check_eq("cnt_pulses", n_ur, 3);
    check_eq("cnt_value", underrun_cnt, 3);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check_eq("cnt_cleared", underrun_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
